// File: rtl/multicycle_pkg.sv
// Shared definitions for the RV32I multi-cycle control path: FSM states,
// opcode constants, and the encodings of the datapath select fields.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        ALU_WB,
        BRANCH,
        JUMP,
        ERR,
        TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_B    = 3'd2;
    localparam logic [2:0] IMM_J    = 3'd3;
    localparam logic [2:0] IMM_NONE = 3'd4;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_TARGET = 2'd1;
    localparam logic [1:0] PC_ALU    = 2'd2;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    // Immediate format implied by an opcode; R-type and unknown opcodes carry none.
    function automatic logic [2:0] imm_for_opcode(input logic [6:0] op);
        case (op)
            OP_I, OP_LOAD, OP_JALR: imm_for_opcode = IMM_I;
            OP_STORE:               imm_for_opcode = IMM_S;
            OP_BRANCH:              imm_for_opcode = IMM_B;
            OP_JAL:                 imm_for_opcode = IMM_J;
            default:                imm_for_opcode = IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle of the memory handshake, datapath status and datapath control
// signals between the sequencer (master) and the datapath/memory (slave).
interface multicycle_control_if #(parameter int WIDTH = 32);

    logic [WIDTH-1:0] instr;
    logic             mem_ready;
    logic             alu_zero;

    logic             mem_req;
    logic             mem_we;
    logic             addr_sel;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic             alu_src_b;
    logic [1:0]       alu_op;
    logic [2:0]       imm_sel;
    logic             reg_write;
    logic [1:0]       result_src;
    logic             busy;
    logic             bus_err;
    logic             trap;

    modport master (
        input  instr, mem_ready, alu_zero,
        output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, imm_sel, reg_write,
               result_src, busy, bus_err, trap
    );

    modport slave (
        output instr, mem_ready, alu_zero,
        input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, imm_sel, reg_write,
               result_src, busy, bus_err, trap
    );

endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Wait-state watchdog for the memory port: counts consecutive request
// cycles without mem_ready and flags the cycle in which the limit is hit.
module mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ready,
    input  logic clear,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(MEM_WAIT_MAX - 1);

    logic [7:0] count;

    // Count unanswered request cycles; any completion, idle cycle or state change restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || ready || !req) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

    // A completion in the limit cycle takes priority, so expiry requires ready low.
    assign expired = req && !ready && (count == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control sequencer (FETCH/DECODE/EXECUTE/MEM/WRITEBACK).
// Build option: define ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise
// an illegal opcode retires as a NOP.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_control_if.master    bus
);

    state_t     state;
    state_t     next_state;
    logic [6:0] opcode;
    logic       started;
    logic       mem_phase;
    logic       expired;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^bus.instr[WIDTH-1:7];

    assign mem_phase = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

    mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (mem_phase),
        .ready   (bus.mem_ready),
        .clear   (next_state != state),
        .expired (expired)
    );

    // Next-state selection; memory phases wait on mem_ready and fall into ERR on timeout.
    always_comb begin
        next_state = state;
        case (state)
            FETCH: begin
                if (bus.mem_ready)  next_state = DECODE;
                else if (expired)   next_state = ERR;
            end
            DECODE: begin
                case (opcode)
                    OP_R:              next_state = EXEC_R;
                    OP_I:              next_state = EXEC_I;
                    OP_LOAD, OP_STORE: next_state = ADDR;
                    OP_BRANCH:         next_state = BRANCH;
                    OP_JAL, OP_JALR:   next_state = JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:           next_state = TRAP;
`else
                    default:           next_state = FETCH;
`endif
                endcase
            end
            EXEC_R, EXEC_I: next_state = ALU_WB;
            ALU_WB:         next_state = FETCH;
            ADDR:           next_state = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
            MEM_RD: begin
                if (bus.mem_ready)  next_state = MEM_WB;
                else if (expired)   next_state = ERR;
            end
            MEM_WB:         next_state = FETCH;
            MEM_WR: begin
                if (bus.mem_ready)  next_state = FETCH;
                else if (expired)   next_state = ERR;
            end
            BRANCH, JUMP:   next_state = FETCH;
            ERR, TRAP:      next_state = state;
            default:        next_state = FETCH;
        endcase
    end

    // State, latched opcode and the "first fetch done" flag that qualifies busy in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            opcode  <= '0;
            started <= 1'b0;
        end else begin
            state <= next_state;
            if (state == FETCH && bus.mem_ready) begin
                opcode  <= bus.instr[6:0];
                started <= 1'b1;
            end
        end
    end

    // Control decode from state and opcode; everything is forced low while reset is asserted.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.addr_sel   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = PC_PLUS4;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 1'b0;
        bus.alu_op     = ALU_ADD;
        bus.imm_sel    = IMM_I;
        bus.reg_write  = 1'b0;
        bus.result_src = RES_ALU;
        bus.busy       = 1'b0;
        bus.bus_err    = 1'b0;
        bus.trap       = 1'b0;
        if (rst_n) begin
            bus.busy = (state != FETCH) || started;
            case (state)
                FETCH: begin
                    bus.mem_req  = 1'b1;
                    bus.ir_write = bus.mem_ready;
                    bus.pc_write = bus.mem_ready;
                end
                DECODE: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 1'b1;
                    bus.imm_sel   = imm_for_opcode(opcode);
                end
                EXEC_R: begin
                    bus.alu_op  = ALU_FUNCT;
                    bus.imm_sel = IMM_NONE;
                end
                EXEC_I: begin
                    bus.alu_op    = ALU_FUNCT;
                    bus.alu_src_b = 1'b1;
                end
                ALU_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.result_src = RES_ALU;
                end
                ADDR: begin
                    bus.alu_src_b = 1'b1;
                    bus.imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                end
                MEM_RD: begin
                    bus.mem_req  = 1'b1;
                    bus.addr_sel = 1'b1;
                end
                MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.result_src = RES_MEM;
                end
                MEM_WR: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_we   = 1'b1;
                    bus.addr_sel = 1'b1;
                end
                BRANCH: begin
                    bus.alu_op   = ALU_SUB;
                    bus.imm_sel  = IMM_B;
                    bus.pc_write = bus.alu_zero;
                    bus.pc_src   = PC_TARGET;
                end
                JUMP: begin
                    // JALR target is rs1+imm from the ALU, so the immediate feeds ALU port B.
                    bus.reg_write  = 1'b1;
                    bus.result_src = RES_PC4;
                    bus.pc_write   = 1'b1;
                    if (opcode == OP_JALR) begin
                        bus.pc_src    = PC_ALU;
                        bus.imm_sel   = IMM_I;
                        bus.alu_src_b = 1'b1;
                    end else begin
                        bus.pc_src  = PC_TARGET;
                        bus.imm_sel = IMM_J;
                    end
                end
                ERR: begin
                    bus.bus_err = 1'b1;
                end
`ifdef ILLEGAL_TRAP_EN
                TRAP: begin
                    bus.trap = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the RV32I datapath: FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK.
- Decodes the latched instruction opcode.
- Drives register-file, ALU, PC, memory and immediate-format controls.
- Handshakes with a variable-latency memory port and guards that port with a wait-state timeout.
- Replaces the single-cycle control path; the immediate generator, ALU and register file stay as they are.

Parameters:
- WIDTH, 32, datapath/instruction width.
- MEM_WAIT_MAX, 15, max cycles a memory request may wait for mem_ready before bus error (1..255).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  WIDTH  memory read data during FETCH (instruction word)
- mem_ready  in  1  memory completes current request this cycle
- alu_zero  in  1  ALU zero flag
- mem_req  out  1  memory request strobe
- mem_we  out  1  1 = write request
- addr_sel  out  1  0 = PC, 1 = ALU result as memory address
- ir_write  out  1  latch instr into IR
- pc_write  out  1  update PC
- pc_src  out  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = ALU result & ~1 (JALR)
- alu_src_a  out  1  0 = rs1, 1 = PC
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  0 = add, 1 = sub (compare), 2 = funct-decoded
- imm_sel  out  3  immediate format to the immediate generator
- reg_write  out  1  register-file write enable
- result_src  out  2  0 = ALU, 1 = memory data, 2 = PC+4
- busy  out  1  high in every state except FETCH-idle-after-reset
- bus_err  out  1  sticky memory timeout flag
- trap  out  1  sticky illegal-instruction flag (feature-dependent)

Behaviour:
- States:
  - FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP, ERR, TRAP.
- Output timing:
  - All outputs are decoded from the state register and the latched opcode (IR[6:0], held internally).
  - Exception: ir_write/pc_write in FETCH and the exit of MEM_RD/MEM_WR are gated by mem_ready.
- Reset (async, rst_n=0):
  - State = FETCH, wait counter = 0, opcode register = 0.
  - bus_err = 0, trap = 0, busy = 0; all strobes/enables low; selects 0.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0; opcode latched from instr[6:0]; go to DECODE.
- DECODE:
  - alu_src_a=1, alu_src_b=1, alu_op=0, imm_sel per opcode.
  - Opcode dispatch:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> ADDR
    - 1100011 -> BRANCH
    - 1101111 or 1100111 -> JUMP
    - other -> illegal (see Optional Feature)
- EXEC_R: alu_op=2, alu_src_b=0 -> ALU_WB.
- EXEC_I: alu_op=2, alu_src_b=1, imm_sel=I -> ALU_WB.
- ALU_WB: reg_write=1, result_src=0 -> FETCH.
- ADDR: alu_op=0, alu_src_b=1; imm_sel=I for load, S for store -> MEM_RD (load) / MEM_WR (store).
- MEM_RD:
  - mem_req=1, addr_sel=1.
  - Hold until mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, result_src=1 -> FETCH.
- MEM_WR:
  - mem_req=1, mem_we=1, addr_sel=1.
  - Hold until mem_ready -> FETCH.
- BRANCH:
  - alu_op=1, alu_src_b=0, imm_sel=B.
  - pc_write = alu_zero, pc_src=1 (beq semantics) -> FETCH.
- JUMP:
  - reg_write=1, result_src=2, pc_write=1.
  - pc_src=1 for JAL (imm_sel=J), pc_src=2 for JALR (imm_sel=I) -> FETCH.
- Latency, zero-wait memory:
  - R/I-ALU 4 cycles, load 5, store 4, branch 3, jump 3.
  - Each memory wait cycle adds 1.
- Timeout:
  - An 8-bit counter counts consecutive mem_req cycles without mem_ready; it clears on mem_ready or on state exit.
  - When the count reaches MEM_WAIT_MAX, go to ERR: bus_err=1, all enables/strobes 0.
  - ERR is held until reset.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- mem_ready arriving in the same cycle the counter reaches MEM_WAIT_MAX: completion wins, no error.
- Reset mid-instruction: immediate return to FETCH; no partial reg_write or pc_write.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE -> TRAP.
  - trap=1 (sticky); all enables/strobes 0; busy=1.
  - Held until reset.
- Undefined: an illegal opcode is a NOP.
  - DECODE -> FETCH; no writes (PC already advanced).
  - trap tied 0.

Decomposition:
- Package multicycle_pkg:
  - state enum.
  - Opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR.
  - imm_sel encoding: IMM_I=0, IMM_S=1, IMM_B=2, IMM_J=3, IMM_NONE=4.
  - pc_src, result_src and alu_op encodings.
- One natural sub-module: mem_wait_timer (counter, clear, expiry compare against MEM_WAIT_MAX).

Test Plan:
- addi x1,x0,5 (0x00500093), mem_ready always 1 -> FETCH, DECODE, EXEC_I, ALU_WB; reg_write=1 in cycle 4 only; imm_sel=0 in DECODE/EXEC_I.
- lw (0x0000A103) with mem_ready low 3 cycles in MEM_RD -> mem_req high 4 cycles in MEM_RD; reg_write with result_src=1 in cycle 8; bus_err=0.
- beq (0x00208463) with alu_zero=1, then again with alu_zero=0 -> pc_write=1/pc_src=1 in BRANCH, then pc_write=0; both return to FETCH after 3 cycles.
- FETCH with mem_ready held 0 -> bus_err rises after exactly 15 request cycles; mem_ready asserted on cycle 15 instead -> no error.
- Opcode 0x0000007F -> with ILLEGAL_TRAP_EN trap=1 and FSM stuck; without it, back to FETCH, trap=0, no reg_write.
- rst_n pulsed low during MEM_WR -> all outputs 0 asynchronously; next fetch starts in FETCH with bus_err=0 and trap=0.
